// File: rtl/dcache_fill_fsm.sv
// D-cache miss fill responder: on a MEM-stage miss it streams the whole block from main memory
// into the data array, then writes the tag. Optional miss counter behind DCACHE_MISS_CNT_EN.
module dcache_fill_fsm #(
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned OFF_W           = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    output logic              cache_stall_n,
    output logic              fsm_busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] fill_address,
    output logic              write_tag_array
`ifdef DCACHE_MISS_CNT_EN
    ,
    output logic [15:0]       miss_count
`endif
);

    localparam int unsigned CNT_W = $clog2(WORDS_PER_BLOCK) + 1;
    localparam int unsigned IDX_W = CNT_W - 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    localparam logic [CNT_W-1:0]  WPB      = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0]  LAST_RSP = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

    logic [0:0]        state_q,   state_d;
    logic [ADDR_W-1:0] base_q,    base_d;
    logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]  rsp_cnt_q, rsp_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
        end
    end

    // Word offsets are OR-ed into the aligned base so addresses never carry out of the block.
    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        req_cnt_d        = req_cnt_q;
        rsp_cnt_d        = rsp_cnt_q;
        fsm_busy         = 1'b0;
        mem_rd_en        = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_address     = '0;
        write_tag_array  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (miss_detected) begin
                    state_d   = S_FILL;
                    base_d    = miss_address & ~OFF_MASK;
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                end
            end
            S_FILL: begin
                fsm_busy = 1'b1;
                if (req_cnt_q < WPB) begin
                    mem_rd_en      = 1'b1;
                    memory_address = base_q | ADDR_W'({req_cnt_q[IDX_W-1:0], 1'b0});
                    req_cnt_d      = req_cnt_q + CNT_W'(1);
                end
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    fill_address     = base_q | ADDR_W'({rsp_cnt_q[IDX_W-1:0], 1'b0});
                    rsp_cnt_d        = rsp_cnt_q + CNT_W'(1);
                    if (rsp_cnt_q == LAST_RSP) begin
                        write_tag_array = 1'b1;
                        state_d         = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        cache_stall_n = ~(fsm_busy | ((state_q == S_IDLE) & miss_detected));
    end

`ifdef DCACHE_MISS_CNT_EN
    logic [15:0] miss_cnt_q, miss_cnt_d;
    logic        miss_accept;

    assign miss_accept = (state_q == S_IDLE) & miss_detected;

    // Saturating count of accepted misses.
    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (miss_accept && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt_q <= '0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_fill_fsm.sv
// Bench for dcache_fill_fsm: directed latency table, hand-written corner sequences and a
// randomized run against a transaction-level model with a variable-latency in-order memory.
module tb_dcache_fill_fsm;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic        cache_stall_n;
    logic        fsm_busy;
    logic        mem_rd_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] fill_address;
    logic        write_tag_array;
`ifdef DCACHE_MISS_CNT_EN
    logic [15:0] miss_count;
`endif

    dcache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .cache_stall_n     (cache_stall_n),
        .fsm_busy          (fsm_busy),
        .mem_rd_en         (mem_rd_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_address      (fill_address),
        .write_tag_array   (write_tag_array)
`ifdef DCACHE_MISS_CNT_EN
        ,
        .miss_count        (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model of the fill: is a block in flight, its base, words requested, words received.
    bit m_busy;
    int m_base;
    int m_iss;
    int m_ret;

    // In-order memory: due cycle of each outstanding word.
    int due[$];
    int cyc = 0;
    int mem_lat = 4;

    // Values observed at the last sample point plus event counters for the hand sequences.
    bit        o_stall, o_busy, o_rd, o_wd, o_tag;
    logic [15:0] o_maddr, o_faddr;
    int cnt_rd, cnt_wd, cnt_tag, saw_zero, max_addr;

    typedef struct {
        bit          miss;
        logic [15:0] addr;
        bit          valid;
        bit          e_stall_n;
        bit          e_busy;
        bit          e_rd;
        logic [15:0] e_maddr;
        bit          e_wd;
        logic [15:0] e_faddr;
        bit          e_tag;
    } vec_t;

    vec_t tbl[14];

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic bit mem_valid();
        return (due.size() != 0) && (due[0] == cyc);
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_base = 0; m_iss = 0; m_ret = 0;
    endfunction

    function automatic void clear_counts();
        cnt_rd = 0; cnt_wd = 0; cnt_tag = 0; saw_zero = 0; max_addr = 0;
    endfunction

    // One clock: drive inputs, compare at the falling edge against the model, advance the model.
    task automatic step(input bit r, input bit ms, input logic [15:0] a, input bit v);
        bit e_rd, e_wd, e_tag;
        int e_maddr, e_faddr, d;
        rst = r; miss_detected = ms; miss_address = a; memory_data_valid = v;
        @(negedge clk);
        o_stall = cache_stall_n; o_busy = fsm_busy; o_rd = mem_rd_en; o_wd = write_data_array;
        o_tag = write_tag_array; o_maddr = memory_address; o_faddr = fill_address;

        e_rd    = m_busy && (m_iss < 8);
        e_maddr = e_rd ? (m_base + 2 * m_iss) : 0;
        e_wd    = m_busy && v;
        e_faddr = e_wd ? (m_base + 2 * (m_ret % 8)) : 0;
        e_tag   = e_wd && (m_ret == 7);
        chk("cache_stall_n", int'(o_stall), int'(!(m_busy || ms)));
        chk("fsm_busy", int'(o_busy), int'(m_busy));
        chk("mem_rd_en", int'(o_rd), int'(e_rd));
        chk("memory_address", int'(o_maddr), e_maddr);
        chk("write_data_array", int'(o_wd), int'(e_wd));
        chk("fill_address", int'(o_faddr), e_faddr);
        chk("write_tag_array", int'(o_tag), int'(e_tag));

        if (o_rd) begin
            cnt_rd++;
            if (o_maddr == 16'h0000) saw_zero++;
            if (int'(o_maddr) > max_addr) max_addr = int'(o_maddr);
            d = cyc + mem_lat;
            if (due.size() != 0 && d <= due[$]) d = due[$] + 1;
            due.push_back(d);
        end
        if (o_wd)  cnt_wd++;
        if (o_tag) cnt_tag++;
        while (due.size() != 0 && due[0] <= cyc) void'(due.pop_front());

        if (r) begin
            model_reset();
        end else if (!m_busy && ms) begin
            m_busy = 1; m_base = int'(a) & 32'hFFF0; m_iss = 0; m_ret = 0;
        end else if (m_busy) begin
            if (e_rd) m_iss++;
            if (v) m_ret++;
            if (e_tag) m_busy = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, mem_valid());
    endtask

    task automatic do_fill(input logic [15:0] a);
        int n;
        step(0, 1, a, mem_valid());
        n = 0;
        while (m_busy && n < 60) begin
            step(0, 0, 16'h0, mem_valid());
            n++;
        end
        if (m_busy) chk("fill_timeout", 1, 0);
    endtask

    initial begin
        rst = 1; miss_detected = 0; miss_address = 0; memory_data_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        step(0, 0, 16'h0, 0);

        // Fill of 0x1236 with 4-cycle memory, row k is cycle T+k.
        for (int k = 0; k < 14; k++) begin
            tbl[k].miss      = (k == 0);
            tbl[k].addr      = 16'h1236;
            tbl[k].valid     = (k >= 5 && k <= 12);
            tbl[k].e_stall_n = (k == 13);
            tbl[k].e_busy    = (k >= 1 && k <= 12);
            tbl[k].e_rd      = (k >= 1 && k <= 8);
            tbl[k].e_maddr   = tbl[k].e_rd ? 16'(16'h1230 + 2 * (k - 1)) : 16'h0;
            tbl[k].e_wd      = tbl[k].valid;
            tbl[k].e_faddr   = tbl[k].e_wd ? 16'(16'h1230 + 2 * (k - 5)) : 16'h0;
            tbl[k].e_tag     = (k == 12);
        end
        for (int k = 0; k < 14; k++) begin
            step(0, tbl[k].miss, tbl[k].addr, tbl[k].valid);
            chk("tbl_stall_n", int'(o_stall), int'(tbl[k].e_stall_n));
            chk("tbl_busy", int'(o_busy), int'(tbl[k].e_busy));
            chk("tbl_rd", int'(o_rd), int'(tbl[k].e_rd));
            chk("tbl_maddr", int'(o_maddr), int'(tbl[k].e_maddr));
            chk("tbl_wd", int'(o_wd), int'(tbl[k].e_wd));
            chk("tbl_faddr", int'(o_faddr), int'(tbl[k].e_faddr));
            chk("tbl_tag", int'(o_tag), int'(tbl[k].e_tag));
        end
        due.delete();
        idle(2);

        // Top-of-memory block: offsets must not carry into address 0.
        clear_counts();
        do_fill(16'hFFFA);
        chk("wrap_req_count", cnt_rd, 8);
        chk("wrap_zero_addr", saw_zero, 0);
        chk("wrap_max_addr", max_addr, 32'hFFFE);
        idle(3);

        // A second miss during a fill is ignored.
        clear_counts();
        step(0, 1, 16'h1230, mem_valid());
        idle(2);
        step(0, 1, 16'h4000, mem_valid());
        idle(20);
        chk("busy_miss_tags", cnt_tag, 1);
        chk("busy_miss_reqs", cnt_rd, 8);
        chk("busy_miss_idle", int'(o_busy), 0);

        // Reset in the middle of a fill, followed by stale returns.
        step(0, 1, 16'h2468, 0);
        for (int k = 1; k <= 5; k++) step(0, 0, 16'h0, 0);
        step(1, 0, 16'h0, 0);
        clear_counts();
        step(0, 0, 16'h0, 1);
        chk("rst_mid_busy", int'(o_busy), 0);
        chk("rst_mid_stall_n", int'(o_stall), 1);
        for (int k = 8; k <= 12; k++) step(0, 0, 16'h0, 1);
        chk("rst_stale_wd", cnt_wd, 0);
        chk("rst_stale_tag", cnt_tag, 0);
        due.delete();
        idle(2);

        // Randomized misses and memory latency.
        for (int i = 0; i < 600; i++) begin
            mem_lat = int'($urandom_range(1, 7));
            step(0, ($urandom_range(0, 3) == 0), 16'($urandom), mem_valid());
        end
        idle(40);

`ifdef DCACHE_MISS_CNT_EN
        step(1, 0, 16'h0, 0);
        due.delete();
        step(0, 0, 16'h0, 0);
        chk("miss_count_reset", int'(miss_count), 0);
        mem_lat = 4;
        for (int f = 0; f < 3; f++) do_fill(16'(16'h3000 + 16 * f));
        chk("miss_count_three", int'(miss_count), 3);
        force dut.miss_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.miss_cnt_q;
        @(posedge clk);
        #1;
        idle(1);
        do_fill(16'h5000);
        idle(2);
        chk("miss_count_sat", int'(miss_count), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
